mm_tile_sender: RTL and testbench

- Source-side formatter for mm_adder: accepts a row-major M x N matrix one full row per beat and emits M_TILE x N_TILE tiles with their tile coordinates (ptr_row, ptr_col).
- Sits between row-streaming producers (memory reader, upstream MM unit) and mm_adder's tile input port.
- Buffers one band of M_TILE rows, then sends that band's N/N_TILE tiles over a valid/ready handshake.

---
 rtl/mm_tile_sender_pkg.sv | 25 ++
 rtl/mm_tile_sender_if.sv | 30 +++
 rtl/mm_tile_sender_band_buffer.sv | 50 +++++
 rtl/mm_tile_sender.sv | 205 ++++++++++++++++++++
 tb/tb_mm_tile_sender.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_tile_sender_pkg.sv
// Shared definitions for the tile sender: sender state encoding and
// small elaboration-time helpers for loop counts and index widths.
package mm_tile_sender_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Number of tiles along one dimension.
    function automatic int iter_count(input int dim, input int tile);
        return dim / tile;
    endfunction

    // Counter width able to index n entries (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of element idx inside a packed vector of dw-bit elements.
    function automatic int elem_lsb(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/mm_tile_sender_if.sv
// Row-in / tile-out bus of the tile sender.
// master: the sender itself (accepts rows, drives tiles).
// slave : the surrounding logic (drives rows, takes tiles).
interface mm_tile_sender_if #(
    parameter int DW_ADD = 32,
    parameter int N      = 4,
    parameter int M_TILE = 2,
    parameter int N_TILE = 2,
    parameter int DW_INT = 8
);
    logic [DW_ADD*N-1:0]               in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [DW_ADD*M_TILE*N_TILE-1:0]   out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [DW_INT-1:0]                 ptr_row;
    logic [DW_INT-1:0]                 ptr_col;
    logic                              last_tile;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, ptr_row, ptr_col, last_tile
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, ptr_row, ptr_col, last_tile
    );
endinterface

// File: rtl/mm_tile_sender_band_buffer.sv
// One band of M_TILE full matrix rows. Rows are written whole; the read
// side selects one tile column and packs it as element (mi,ni) at
// index mi*N_TILE+ni. Contents are not reset: they are only ever read
// after a complete band has been written.
module mm_tile_sender_band_buffer
    import mm_tile_sender_pkg::*;
#(
    parameter int M_TILE = 2,
    parameter int N      = 4,
    parameter int N_TILE = 2,
    parameter int DW_ADD = 32,
    parameter int DW_INT = 8
) (
    input  logic                            i_clk,
    input  logic                            i_we,
    input  logic [idx_w(M_TILE)-1:0]        i_row_sel,
    input  logic [DW_ADD*N-1:0]             i_row,
    input  logic [DW_INT-1:0]               i_col_sel,
    output logic [DW_ADD*M_TILE*N_TILE-1:0] o_tile
);
    localparam int ITER_N = iter_count(N, N_TILE);

    logic [DW_ADD*N-1:0]             r_mem [M_TILE];
    logic [DW_ADD*M_TILE*N_TILE-1:0] w_tile;

    // Row write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_row_sel] <= i_row;
        end
    end

    // Tile-column read mux; all slices are constant so the mux is explicit.
    always_comb begin
        w_tile = '0;
        for (int c = 0; c < ITER_N; c++) begin
            if (i_col_sel == DW_INT'(c)) begin
                for (int mi = 0; mi < M_TILE; mi++) begin
                    for (int ni = 0; ni < N_TILE; ni++) begin
                        w_tile[elem_lsb(mi*N_TILE+ni, DW_ADD) +: DW_ADD] =
                            r_mem[mi][elem_lsb(c*N_TILE+ni, DW_ADD) +: DW_ADD];
                    end
                end
            end
        end
    end

    assign o_tile = w_tile;

endmodule

// File: rtl/mm_tile_sender.sv
// Tile sender: collects M_TILE matrix rows into a band buffer, then emits
// that band as N/N_TILE tiles tagged with (ptr_row, ptr_col).
// Build option MM_TILE_PINGPONG_EN: two band buffers so the next band
// fills while the current one is being sent.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_FILL | accepting rows into the band buffer (in_ready high)
// ST_SEND | presenting the buffered band tile by tile (out_valid high)
module mm_tile_sender
    import mm_tile_sender_pkg::*;
#(
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int M_TILE = 2,
    parameter int N_TILE = 2,
    parameter int DW_ADD = 32,
    parameter int DW_INT = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    mm_tile_sender_if.master  bus
);
    localparam int ITER_M = iter_count(M, M_TILE);
    localparam int ITER_N = iter_count(N, N_TILE);
    localparam int RW     = idx_w(M_TILE);
    localparam int TW     = DW_ADD * M_TILE * N_TILE;

    localparam logic [RW-1:0]     LAST_ROW  = RW'(M_TILE - 1);
    localparam logic [DW_INT-1:0] LAST_COL  = DW_INT'(ITER_N - 1);
    localparam logic [DW_INT-1:0] LAST_BAND = DW_INT'(ITER_M - 1);

    logic              r_in_rdy;
    logic              r_out_valid;
    logic [RW-1:0]     r_row_cnt;
    logic [DW_INT-1:0] r_ptr_row;
    logic [DW_INT-1:0] r_ptr_col;

    logic              w_in_hs;
    logic              w_out_hs;
    logic [TW-1:0]     w_tile;

    assign w_in_hs  = i_enable & r_in_rdy & bus.in_valid;
    assign w_out_hs = i_enable & r_out_valid & bus.out_ready;

    assign bus.in_ready  = r_in_rdy & i_enable;
    assign bus.out_valid = r_out_valid;
    // Buffer contents are undefined until a band is complete; keep the bus quiet.
    assign bus.out_data  = r_out_valid ? w_tile : '0;
    assign bus.ptr_row   = r_ptr_row;
    assign bus.ptr_col   = r_ptr_col;
    assign bus.last_tile = r_out_valid & (r_ptr_row == LAST_BAND) & (r_ptr_col == LAST_COL);

`ifdef MM_TILE_PINGPONG_EN

    logic [1:0]    r_full;
    logic          r_wr_sel;
    logic          r_rd_sel;
    logic [1:0]    w_full_nxt;
    logic          w_wr_nxt;
    logic          w_rd_nxt;
    logic          w_fill_done;
    logic          w_send_done;
    logic [TW-1:0] w_tile0;
    logic [TW-1:0] w_tile1;

    assign w_fill_done = w_in_hs & (r_row_cnt == LAST_ROW);
    assign w_send_done = w_out_hs & (r_ptr_col == LAST_COL);
    assign w_tile      = r_rd_sel ? w_tile1 : w_tile0;

    mm_tile_sender_band_buffer #(
        .M_TILE (M_TILE), .N (N), .N_TILE (N_TILE), .DW_ADD (DW_ADD), .DW_INT (DW_INT)
    ) u_buf0 (
        .i_clk     (i_clk),
        .i_we      (w_in_hs & ~r_wr_sel),
        .i_row_sel (r_row_cnt),
        .i_row     (bus.in_data),
        .i_col_sel (r_ptr_col),
        .o_tile    (w_tile0)
    );

    mm_tile_sender_band_buffer #(
        .M_TILE (M_TILE), .N (N), .N_TILE (N_TILE), .DW_ADD (DW_ADD), .DW_INT (DW_INT)
    ) u_buf1 (
        .i_clk     (i_clk),
        .i_we      (w_in_hs & r_wr_sel),
        .i_row_sel (r_row_cnt),
        .i_row     (bus.in_data),
        .i_col_sel (r_ptr_col),
        .o_tile    (w_tile1)
    );

    // Buffer ownership: a fill marks its buffer full, the last tile frees it.
    // Fill and send never target the same buffer: both-empty blocks sending,
    // both-full blocks filling.
    always_comb begin
        w_full_nxt = r_full;
        if (w_fill_done) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
        if (w_send_done) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
        w_wr_nxt = r_wr_sel ^ w_fill_done;
        w_rd_nxt = r_rd_sel ^ w_send_done;
    end

    // Buffer flags, handshake outputs and row/tile counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full      <= 2'b00;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_out_valid <= 1'b0;
            r_row_cnt   <= '0;
            r_ptr_row   <= '0;
            r_ptr_col   <= '0;
        end else begin
            r_full      <= w_full_nxt;
            r_wr_sel    <= w_wr_nxt;
            r_rd_sel    <= w_rd_nxt;
            r_in_rdy    <= ~w_full_nxt[w_wr_nxt];
            r_out_valid <= w_full_nxt[w_rd_nxt];
            if (w_in_hs) begin
                r_row_cnt <= w_fill_done ? '0 : r_row_cnt + 1'b1;
            end
            if (w_out_hs) begin
                if (r_ptr_col == LAST_COL) begin
                    r_ptr_col <= '0;
                    r_ptr_row <= (r_ptr_row == LAST_BAND) ? '0 : r_ptr_row + 1'b1;
                end else begin
                    r_ptr_col <= r_ptr_col + 1'b1;
                end
            end
        end
    end

`else

    state_t r_state;

    mm_tile_sender_band_buffer #(
        .M_TILE (M_TILE), .N (N), .N_TILE (N_TILE), .DW_ADD (DW_ADD), .DW_INT (DW_INT)
    ) u_buf (
        .i_clk     (i_clk),
        .i_we      (w_in_hs),
        .i_row_sel (r_row_cnt),
        .i_row     (bus.in_data),
        .i_col_sel (r_ptr_col),
        .o_tile    (w_tile)
    );

    // Fill/send sequencer with registered handshake outputs. in_ready is
    // raised from FILL even while enable is low so it comes up one cycle
    // after reset regardless of enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_FILL;
            r_in_rdy    <= 1'b0;
            r_out_valid <= 1'b0;
            r_row_cnt   <= '0;
            r_ptr_row   <= '0;
            r_ptr_col   <= '0;
        end else begin
            if (r_state == ST_FILL) begin
                r_in_rdy <= 1'b1;
            end
            if (i_enable) begin
                case (r_state)
                    ST_FILL: begin
                        if (w_in_hs) begin
                            if (r_row_cnt == LAST_ROW) begin
                                r_row_cnt   <= '0;
                                r_state     <= ST_SEND;
                                r_out_valid <= 1'b1;
                                r_in_rdy    <= 1'b0;
                            end else begin
                                r_row_cnt <= r_row_cnt + 1'b1;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (w_out_hs) begin
                            if (r_ptr_col == LAST_COL) begin
                                r_ptr_col   <= '0;
                                r_ptr_row   <= (r_ptr_row == LAST_BAND) ? '0 : r_ptr_row + 1'b1;
                                r_state     <= ST_FILL;
                                r_out_valid <= 1'b0;
                                r_in_rdy    <= 1'b1;
                            end else begin
                                r_ptr_col <= r_ptr_col + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_FILL;
                endcase
            end
        end
    end

`endif

endmodule

// File: tb/tb_mm_tile_sender.sv
module tb_mm_tile_sender;

    localparam int M      = 4;
    localparam int N      = 4;
    localparam int MT     = 2;
    localparam int NT     = 2;
    localparam int DW     = 32;
    localparam int DI     = 8;
    localparam int ITER_M = M / MT;
    localparam int ITER_N = N / NT;
    localparam int RWID   = DW * N;
    localparam int TWID   = DW * MT * NT;
`ifdef MM_TILE_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef struct {
        logic [TWID-1:0] data;
        int              pr;
        int              pc;
        bit              last;
    } tile_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    mm_tile_sender_if #(.DW_ADD(DW), .N(N), .M_TILE(MT), .N_TILE(NT), .DW_INT(DI)) bus ();

    mm_tile_sender #(
        .M(M), .N(N), .M_TILE(MT), .N_TILE(NT), .DW_ADD(DW), .DW_INT(DI)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_enable (enable),
        .bus      (bus)
    );

    // Reference model: rows collect into a band; a complete band turns into
    // ITER_N expected tiles. The DUT must present the head of the queue
    // whenever it is non-empty.
    tile_t            exp_q[$];
    logic [RWID-1:0]  band[$];
    int               m_band;
    bit               m_fresh;
    bit               hs_in;
    bit               hs_out;
    int               vectors;
    int               miscompares;

    function automatic logic [RWID-1:0] pat_row(input int r);
        logic [RWID-1:0] v;
        for (int c = 0; c < N; c++) v[DW*c +: DW] = DW'(r * N + c);
        return v;
    endfunction

    function automatic logic [RWID-1:0] rnd_row();
        logic [RWID-1:0] v;
        for (int c = 0; c < N; c++) v[DW*c +: DW] = $urandom;
        return v;
    endfunction

    function automatic logic [TWID-1:0] pat_tile(input int pr, input int pc);
        logic [TWID-1:0] v;
        for (int mi = 0; mi < MT; mi++)
            for (int ni = 0; ni < NT; ni++)
                v[DW*(mi*NT+ni) +: DW] = DW'((pr * MT + mi) * N + pc * NT + ni);
        return v;
    endfunction

    // Bands buffered but not completely sent; a row is accepted only while
    // a buffer is free (one buffer, or two with ping-pong).
    function automatic bit m_rdy();
        int pend;
        pend = (exp_q.size() + ITER_N - 1) / ITER_N;
        if (m_fresh) return 1'b0;
        return PP ? (pend < 2) : (pend == 0);
    endfunction

    function automatic void m_push_band();
        tile_t           t;
        logic [RWID-1:0] row;
        for (int pc = 0; pc < ITER_N; pc++) begin
            for (int mi = 0; mi < MT; mi++) begin
                row = band[mi];
                for (int ni = 0; ni < NT; ni++)
                    t.data[DW*(mi*NT+ni) +: DW] = row[DW*(pc*NT+ni) +: DW];
            end
            t.pr   = m_band;
            t.pc   = pc;
            t.last = (m_band == ITER_M - 1) && (pc == ITER_N - 1);
            exp_q.push_back(t);
        end
        band.delete();
        m_band = (m_band + 1) % ITER_M;
    endfunction

    // Drive one cycle from a negedge, update the model at the posedge and
    // return at the following negedge.
    task automatic cycle(input bit en, input bit iv, input logic [RWID-1:0] row, input bit ordy);
        enable        = en;
        bus.in_valid  = iv;
        bus.in_data   = row;
        bus.out_ready = ordy;
        hs_in  = en && iv && m_rdy();
        hs_out = en && ordy && (exp_q.size() > 0);
        @(posedge clk);
        m_fresh = 1'b0;
        if (hs_out) void'(exp_q.pop_front());
        if (hs_in) begin
            band.push_back(row);
            if (band.size() == MT) m_push_band();
        end
        @(negedge clk);
    endtask

    task automatic test_reset(input string tag);
        @(negedge clk);
        reset         = 1'b1;
        enable        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL %s rst_in_ready: got %b want 0", tag, bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL %s rst_out_valid: got %b want 0", tag, bus.out_valid); end
        vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL %s rst_out: got %h want 0", tag, bus.out_data); end
        vectors++; if (bus.ptr_row !== '0) begin miscompares++; $display("FAIL %s rst_ptr_row: got %0d want 0", tag, bus.ptr_row); end
        vectors++; if (bus.ptr_col !== '0) begin miscompares++; $display("FAIL %s rst_ptr_col: got %0d want 0", tag, bus.ptr_col); end
        vectors++; if (bus.last_tile !== 1'b0) begin miscompares++; $display("FAIL %s rst_last: got %b want 0", tag, bus.last_tile); end
        exp_q.delete();
        band.delete();
        m_band  = 0;
        m_fresh = 1'b1;
        reset   = 1'b0;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL %s in_ready_release: got %b want 0", tag, bus.in_ready); end
        cycle(1'b1, 1'b0, '0, 1'b0);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL %s in_ready_rise: got %b want 1", tag, bus.in_ready); end
    endtask

    // Stream rows [first, last) with random valid/ready/enable and check
    // every cycle against the model.
    task automatic test_traffic(input string tag, input int first, input int last,
                                input int pv, input int pr, input int pe, input bit pattern);
        int              nxt;
        int              cyc;
        bit              exp_rdy;
        tile_t           t;
        logic [RWID-1:0] cur;
        nxt = first;
        cyc = 0;
        cur = pattern ? pat_row(nxt % M) : rnd_row();
        while ((nxt < last || exp_q.size() > 0) && cyc < 4000) begin
            exp_rdy = enable && m_rdy();
            vectors++; if (bus.in_ready !== exp_rdy) begin miscompares++; $display("FAIL %s in_ready: got %b want %b cyc %0d", tag, bus.in_ready, exp_rdy, cyc); end
            vectors++; if (bus.out_valid !== (exp_q.size() > 0)) begin miscompares++; $display("FAIL %s out_valid: got %b want %b cyc %0d", tag, bus.out_valid, exp_q.size() > 0, cyc); end
            if (exp_q.size() > 0) begin
                t = exp_q[0];
                vectors++; if (bus.out_data !== t.data) begin miscompares++; $display("FAIL %s out: got %h want %h cyc %0d", tag, bus.out_data, t.data, cyc); end
                vectors++; if (bus.ptr_row !== DI'(t.pr)) begin miscompares++; $display("FAIL %s ptr_row: got %0d want %0d cyc %0d", tag, bus.ptr_row, t.pr, cyc); end
                vectors++; if (bus.ptr_col !== DI'(t.pc)) begin miscompares++; $display("FAIL %s ptr_col: got %0d want %0d cyc %0d", tag, bus.ptr_col, t.pc, cyc); end
                vectors++; if (bus.last_tile !== t.last) begin miscompares++; $display("FAIL %s last_tile: got %b want %b cyc %0d", tag, bus.last_tile, t.last, cyc); end
                if (pattern) begin
                    vectors++; if (bus.out_data !== pat_tile(t.pr, t.pc)) begin miscompares++; $display("FAIL %s pattern: got %h want %h", tag, bus.out_data, pat_tile(t.pr, t.pc)); end
                end
            end else begin
                vectors++; if (bus.last_tile !== 1'b0) begin miscompares++; $display("FAIL %s idle_last: got %b want 0", tag, bus.last_tile); end
            end
            cycle($urandom_range(99) < pe, (nxt < last) && ($urandom_range(99) < pv), cur, $urandom_range(99) < pr);
            if (hs_in) begin
                nxt++;
                cur = pattern ? pat_row(nxt % M) : rnd_row();
            end
            cyc++;
        end
        vectors++; if (cyc >= 4000) begin miscompares++; $display("FAIL %s timeout: got %0d rows %0d tiles left want drained", tag, nxt, exp_q.size()); end
    endtask

    task automatic test_backpressure();
        test_reset("bp");
        cycle(1'b1, 1'b1, pat_row(0), 1'b1);
        cycle(1'b1, 1'b1, pat_row(1), 1'b1);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp first_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_data !== pat_tile(0, 0)) begin miscompares++; $display("FAIL bp tile00: got %h want %h", bus.out_data, pat_tile(0, 0)); end
        cycle(1'b1, 1'b0, pat_row(2), 1'b1);
        for (int k = 0; k < 4; k++) begin
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp hold_valid: got %b want 1 k %0d", bus.out_valid, k); end
            vectors++; if (bus.out_data !== pat_tile(0, 1)) begin miscompares++; $display("FAIL bp hold_out: got %h want %h k %0d", bus.out_data, pat_tile(0, 1), k); end
            vectors++; if (bus.ptr_row !== DI'(0) || bus.ptr_col !== DI'(1)) begin miscompares++; $display("FAIL bp hold_ptr: got (%0d,%0d) want (0,1)", bus.ptr_row, bus.ptr_col); end
            vectors++; if (bus.last_tile !== 1'b0) begin miscompares++; $display("FAIL bp hold_last: got %b want 0", bus.last_tile); end
            if (!PP) begin
                vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp send_in_ready: got %b want 0 k %0d", bus.in_ready, k); end
            end
            cycle(1'b1, !PP, pat_row(2), k == 3);
        end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp after_band: got %b want 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp refill_ready: got %b want 1", bus.in_ready); end
        test_traffic("bp_tail", 2, M, 100, 100, 100, 1'b1);
    endtask

    task automatic test_reset_mid();
        test_reset("mid_pre");
        cycle(1'b1, 1'b1, pat_row(0), 1'b1);
        cycle(1'b1, 1'b1, pat_row(1), 1'b1);
        cycle(1'b1, 1'b0, pat_row(2), 1'b1);
        vectors++; if (bus.ptr_col !== DI'(1)) begin miscompares++; $display("FAIL mid ptr_col_before: got %0d want 1", bus.ptr_col); end
        test_reset("mid");
        test_traffic("after_reset", 0, M, 100, 100, 100, 1'b1);
    endtask

    task automatic test_pingpong();
        int row3_cyc;
        int last_cyc;
        int nxt;
        int tiles;
        bit rdy;
        bit ov;
        test_reset("pp");
        row3_cyc = -1;
        last_cyc = -1;
        nxt      = 0;
        tiles    = 0;
        for (int c = 0; c < 20; c++) begin
            rdy = bus.in_ready;
            ov  = bus.out_valid;
            if (ov) tiles++;
            if (ov && bus.last_tile) last_cyc = c;
            cycle(1'b1, nxt < M, pat_row(nxt % M), 1'b1);
            if (rdy && nxt < M) begin
                if (nxt == M - 1) row3_cyc = c;
                nxt++;
            end
        end
        vectors++; if (tiles !== ITER_M * ITER_N) begin miscompares++; $display("FAIL pp tiles: got %0d want %0d", tiles, ITER_M * ITER_N); end
        vectors++; if (row3_cyc < 0 || last_cyc < 0 || last_cyc - row3_cyc > 2) begin miscompares++; $display("FAIL pp latency: got row3 %0d last %0d want gap <= 2", row3_cyc, last_cyc); end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        m_band        = 0;
        m_fresh       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        test_reset("por");
        test_traffic("stream", 0, M, 100, 100, 100, 1'b1);
        test_backpressure();
        test_reset("en");
        test_traffic("enable", 0, M, 100, 100, 50, 1'b1);
        test_reset_mid();
        test_reset("rnd");
        test_traffic("random", 0, 3 * M, 70, 60, 85, 1'b0);
        test_reset("b2b");
        test_traffic("back_to_back", 0, 3 * M, 100, 100, 100, 1'b1);
        if (PP) test_pingpong();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
